// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (CPU / DMA) for a single fixed-wait-state memory port.
// Round-robin on contention; request fields are latched at grant.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWdata,
  output logic [DATA_W-1:0] cpuRdata,
  output logic              cpuAck,
  input  logic              dmaReq,
  input  logic              dmaWe,
  input  logic [ADDR_W-1:0] dmaAddr,
  input  logic [DATA_W-1:0] dmaWdata,
  output logic [DATA_W-1:0] dmaRdata,
  output logic              dmaAck,
  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t            state, nextState;
  logic              lastGrant;
  logic              weReg;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] wdataReg;
  logic [3:0]        waitCnt;

  logic grant;
  logic grantSel;
  logic capture;

  always_comb begin
    nextState = state;
    grant     = 1'b0;
    grantSel  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (cpuReq && dmaReq) begin
          grant    = 1'b1;
          grantSel = ~lastGrant;
        end else if (cpuReq) begin
          grant    = 1'b1;
          grantSel = 1'b0;
        end else if (dmaReq) begin
          grant    = 1'b1;
          grantSel = 1'b1;
        end
        if (grant) nextState = ACCESS;
      end
      ACCESS: begin
        if (waitCnt == 4'd0) begin
          capture   = ~weReg;
          nextState = RESP;
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      owner     <= 1'b0;
      weReg     <= 1'b0;
      addrReg   <= '0;
      wdataReg  <= '0;
      waitCnt   <= '0;
      cpuRdata  <= '0;
      dmaRdata  <= '0;
    end else begin
      state <= nextState;
      if (grant) begin
        owner     <= grantSel;
        lastGrant <= grantSel;
        weReg     <= grantSel ? dmaWe    : cpuWe;
        addrReg   <= grantSel ? dmaAddr  : cpuAddr;
        wdataReg  <= grantSel ? dmaWdata : cpuWdata;
        waitCnt   <= 4'(WAIT - 1);
      end else if (state == ACCESS && waitCnt != 4'd0) begin
        waitCnt <= waitCnt - 4'd1;
      end
      if (capture) begin
        if (owner) dmaRdata <= memRdata;
        else       cpuRdata <= memRdata;
      end
    end
  end

  // Decoded from the state register so an async reset drops memEn/memWe at once.
  assign memEn    = (state == ACCESS);
  assign memWe    = (state == ACCESS) && weReg;
  assign memAddr  = addrReg;
  assign memWdata = wdataReg;
  assign cpuAck   = (state == RESP) && !owner;
  assign dmaAck   = (state == RESP) &&  owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one WAIT=2 instance and one WAIT=1 instance
// sharing stimulus; each section checks only the instance it targets.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpuReq, cpuWe, dmaReq, dmaWe;
  logic [31:0] cpuAddr, cpuWdata, dmaAddr, dmaWdata, memRdata;

  logic [31:0] cpuRdata, dmaRdata, memAddr, memWdata;
  logic        cpuAck, dmaAck, memEn, memWe, owner;

  logic [31:0] cpuRdata1, dmaRdata1, memAddr1, memWdata1;
  logic        cpuAck1, dmaAck1, memEn1, memWe1, owner1;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT(2)) dut (
    .clk(clk), .rst(rst),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
    .cpuRdata(cpuRdata), .cpuAck(cpuAck),
    .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaAddr(dmaAddr), .dmaWdata(dmaWdata),
    .dmaRdata(dmaRdata), .dmaAck(dmaAck),
    .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .owner(owner)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT(1)) dut1 (
    .clk(clk), .rst(rst),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
    .cpuRdata(cpuRdata1), .cpuAck(cpuAck1),
    .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaAddr(dmaAddr), .dmaWdata(dmaWdata),
    .dmaRdata(dmaRdata1), .dmaAck(dmaAck1),
    .memEn(memEn1), .memWe(memWe1), .memAddr(memAddr1), .memWdata(memWdata1),
    .memRdata(memRdata), .owner(owner1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held with both requests high
    rst = 1'b0;
    cpuReq = 1'b1; dmaReq = 1'b1; cpuWe = 1'b0; dmaWe = 1'b0;
    cpuAddr = 32'h10; dmaAddr = 32'h20; cpuWdata = '0; dmaWdata = '0;
    memRdata = 32'h0;
    tick(); tick(); tick();
    chk("rst_memEn", {31'b0, memEn}, 32'd0);
    chk("rst_memWe", {31'b0, memWe}, 32'd0);
    chk("rst_cpuAck", {31'b0, cpuAck}, 32'd0);
    chk("rst_dmaAck", {31'b0, dmaAck}, 32'd0);
    chk("rst_owner", {31'b0, owner}, 32'd0);
    chk("rst_cpuRdata", cpuRdata, 32'd0);
    chk("rst_dmaRdata", dmaRdata, 32'd0);
    chk("rst_memAddr", memAddr, 32'd0);
    chk("rst_memWdata", memWdata, 32'd0);
    rst = 1'b1;
    tick();
    chk("first_tie_owner", {31'b0, owner}, 32'd0);
    chk("first_tie_memEn", {31'b0, memEn}, 32'd1);
    chk("first_tie_memAddr", memAddr, 32'h10);
    cpuReq = 1'b0; dmaReq = 1'b0;
    tick(); tick();
    chk("withdrawn_cpuAck", {31'b0, cpuAck}, 32'd1);
    chk("withdrawn_dmaAck", {31'b0, dmaAck}, 32'd0);
    tick();
    chk("idle_cpuAck", {31'b0, cpuAck}, 32'd0);

    // Single CPU read, WAIT=2
    memRdata = 32'hDEADBEEF;
    cpuReq = 1'b1; cpuAddr = 32'h40; cpuWe = 1'b0;
    tick();
    chk("rd_acc1_memEn", {31'b0, memEn}, 32'd1);
    chk("rd_acc1_memWe", {31'b0, memWe}, 32'd0);
    chk("rd_acc1_memAddr", memAddr, 32'h40);
    chk("rd_acc1_cpuAck", {31'b0, cpuAck}, 32'd0);
    tick();
    chk("rd_acc2_memEn", {31'b0, memEn}, 32'd1);
    chk("rd_acc2_memAddr", memAddr, 32'h40);
    tick();
    chk("rd_resp_cpuAck", {31'b0, cpuAck}, 32'd1);
    chk("rd_resp_memEn", {31'b0, memEn}, 32'd0);
    chk("rd_cpuRdata", cpuRdata, 32'hDEADBEEF);
    chk("rd_dmaRdata", dmaRdata, 32'd0);
    cpuReq = 1'b0;
    tick();
    chk("rd_idle_cpuAck", {31'b0, cpuAck}, 32'd0);
    chk("rd_idle_memEn", {31'b0, memEn}, 32'd0);

    // DMA write; input changes after grant must be ignored
    memRdata = 32'hCAFEF00D;
    dmaReq = 1'b1; dmaWe = 1'b1; dmaAddr = 32'h100; dmaWdata = 32'h12345678;
    tick();
    chk("wr_acc1_memWe", {31'b0, memWe}, 32'd1);
    chk("wr_acc1_memAddr", memAddr, 32'h100);
    chk("wr_acc1_memWdata", memWdata, 32'h12345678);
    chk("wr_acc1_owner", {31'b0, owner}, 32'd1);
    dmaAddr = 32'h200; dmaWdata = 32'hFFFFFFFF;
    tick();
    chk("wr_acc2_memWe", {31'b0, memWe}, 32'd1);
    chk("wr_acc2_memAddr", memAddr, 32'h100);
    chk("wr_acc2_memWdata", memWdata, 32'h12345678);
    tick();
    chk("wr_resp_dmaAck", {31'b0, dmaAck}, 32'd1);
    chk("wr_resp_cpuAck", {31'b0, cpuAck}, 32'd0);
    chk("wr_resp_memWe", {31'b0, memWe}, 32'd0);
    dmaReq = 1'b0;
    tick();
    chk("wr_idle_dmaAck", {31'b0, dmaAck}, 32'd0);
    chk("wr_cpuRdata", cpuRdata, 32'hDEADBEEF);
    chk("wr_dmaRdata", dmaRdata, 32'd0);

    // Contention: last grant was DMA, so order is CPU, DMA, CPU, DMA
    cpuReq = 1'b1; dmaReq = 1'b1; cpuWe = 1'b0; dmaWe = 1'b0;
    cpuAddr = 32'h44; dmaAddr = 32'h104;
    for (int k = 0; k < 4; k++) begin
      logic expOwner;
      expOwner = k[0];
      memRdata = 32'hA0 + k;
      tick();
      chk($sformatf("cont%0d_owner", k), {31'b0, owner}, {31'b0, expOwner});
      chk($sformatf("cont%0d_memAddr", k), memAddr, expOwner ? 32'h104 : 32'h44);
      tick(); tick();
      chk($sformatf("cont%0d_ownAck", k), {31'b0, expOwner ? dmaAck : cpuAck}, 32'd1);
      chk($sformatf("cont%0d_otherAck", k), {31'b0, expOwner ? cpuAck : dmaAck}, 32'd0);
      chk($sformatf("cont%0d_rdata", k), expOwner ? dmaRdata : cpuRdata, 32'hA0 + k);
      if (k == 3) begin
        cpuReq = 1'b0; dmaReq = 1'b0;
      end
      tick();
      chk($sformatf("cont%0d_acksLow", k), {30'b0, cpuAck, dmaAck}, 32'd0);
    end
    chk("cont_cpuRdata_final", cpuRdata, 32'hA2);

    // Reset during the second ACCESS cycle of a CPU write
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 32'h80; cpuWdata = 32'h55AA55AA;
    tick();
    chk("mr_acc1_memWe", {31'b0, memWe}, 32'd1);
    tick();
    chk("mr_acc2_memWe", {31'b0, memWe}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mr_async_memWe", {31'b0, memWe}, 32'd0);
    chk("mr_async_memEn", {31'b0, memEn}, 32'd0);
    dmaReq = 1'b1; dmaWe = 1'b0;
    tick();
    chk("mr_noAck", {30'b0, cpuAck, dmaAck}, 32'd0);
    chk("mr_cpuRdata", cpuRdata, 32'd0);
    tick();
    chk("mr_noAck2", {30'b0, cpuAck, dmaAck}, 32'd0);
    rst = 1'b1;
    tick();
    chk("mr_tie_owner", {31'b0, owner}, 32'd0);
    chk("mr_tie_memAddr", memAddr, 32'h80);
    cpuReq = 1'b0; dmaReq = 1'b0; cpuWe = 1'b0;
    repeat (5) tick();

    // WAIT=1 instance: address change during ACCESS is ignored
    memRdata = 32'h0BADCAFE;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h60;
    tick();
    chk("w1_acc_memEn", {31'b0, memEn1}, 32'd1);
    chk("w1_acc_memAddr", memAddr1, 32'h60);
    cpuAddr = 32'h70;
    #2;
    chk("w1_acc_memAddr_held", memAddr1, 32'h60);
    tick();
    chk("w1_resp_cpuAck", {31'b0, cpuAck1}, 32'd1);
    chk("w1_resp_memEn", {31'b0, memEn1}, 32'd0);
    chk("w1_cpuRdata", cpuRdata1, 32'h0BADCAFE);
    cpuReq = 1'b0;
    tick();
    chk("w1_idle_cpuAck", {31'b0, cpuAck1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
